// File: rtl/wb_result_buffer.sv
// wb_result_buffer: in-order result FIFO between an execution unit's writeback port and the arbiter.
// Optional macro WB_BUFFER_BYPASS_EN adds a zero-latency pass-through while the buffer is empty.
module wb_result_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       unit_done,
  input  logic [ID_WIDTH-1:0]        unit_id,
  input  logic [DATA_WIDTH-1:0]      unit_rd,
  output logic                       unit_ack,
  output logic                       wb_done,
  output logic [ID_WIDTH-1:0]        wb_id,
  output logic [DATA_WIDTH-1:0]      wb_rd,
  input  logic                       wb_ack,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [ID_WIDTH-1:0]   id_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  write;
  logic                  drain;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Acceptance is held off while reset is asserted so upstream never sees an ack it cannot trust.
  assign push     = rst_n & unit_done & ~full;
  assign unit_ack = push;

`ifdef WB_BUFFER_BYPASS_EN
  logic bypass;

  // An empty buffer forwards the upstream result directly; if the arbiter takes it, nothing is stored.
  assign bypass  = rst_n & empty & unit_done;
  assign wb_done = ~empty | bypass;
  assign wb_id   = bypass ? unit_id : id_mem[rd_ptr];
  assign wb_rd   = bypass ? unit_rd : rd_mem[rd_ptr];
  assign pop     = wb_done & wb_ack;
  assign write   = push & ~(bypass & wb_ack);
  assign drain   = pop & ~bypass;
`else
  assign wb_done = ~empty;
  assign wb_id   = id_mem[rd_ptr];
  assign wb_rd   = rd_mem[rd_ptr];
  assign pop     = wb_done & wb_ack;
  assign write   = push;
  assign drain   = pop;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write) wr_ptr <= wr_ptr + PTR_ONE;
      if (drain) rd_ptr <= rd_ptr + PTR_ONE;
      case ({write, drain})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (write) begin
      id_mem[wr_ptr] <= unit_id;
      rd_mem[wr_ptr] <= unit_rd;
    end
  end

endmodule

// File: tb/tb_wb_result_buffer.sv
// Self-checking bench for wb_result_buffer: directed scenarios plus random traffic against a queue model.
module tb_wb_result_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int IW    = 3;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          unit_done;
  logic [IW-1:0] unit_id;
  logic [DW-1:0] unit_rd;
  logic          unit_ack;
  logic          wb_done;
  logic [IW-1:0] wb_id;
  logic [DW-1:0] wb_rd;
  logic          wb_ack;
  logic [CW-1:0] count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] rd;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  wb_result_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .unit_done(unit_done), .unit_id(unit_id), .unit_rd(unit_rd), .unit_ack(unit_ack),
    .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack),
    .count(count)
  );

  // Reference model: an ordered list of stored results, with the pass-through rule layered on top.
  function automatic bit m_ack();
    return unit_done && (q.size() < DEPTH);
  endfunction

  function automatic bit m_done();
    return (q.size() != 0) || (BYP && unit_done);
  endfunction

  function automatic ent_t m_head();
    ent_t e;
    if (q.size() != 0) e = q[0];
    else e = {unit_id, unit_rd};
    return e;
  endfunction

  task automatic drive(input bit d, input logic [IW-1:0] id, input logic [DW-1:0] rd, input bit a);
    @(negedge clk);
    unit_done = d;
    unit_id   = id;
    unit_rd   = rd;
    wb_ack    = a;
    #1;
  endtask

  task automatic step();
    bit   pop;
    bit   push;
    bit   passed;
    pop    = m_done() && wb_ack;
    push   = m_ack();
    passed = BYP && (q.size() == 0) && pop;
    @(posedge clk);
    if (!passed) begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({unit_id, unit_rd});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && q.size() != 0; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    tests++;
    if (count !== '0) begin
      fails++;
      $display("FAIL drain_count: got %0d want 0", count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    unit_done = 1'b1; unit_id = 3'd1; unit_rd = 32'hdead_0001; wb_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (wb_done !== 1'b0 || unit_ack !== 1'b0 || count !== '0) begin
      fails++;
      $display("FAIL reset_state: wb_done=%b unit_ack=%b count=%0d want 0 0 0", wb_done, unit_ack, count);
    end
    rst_n = 1'b1;
    q.delete();
    #1;
    tests++;
    if (unit_ack !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_ack: got %b want 1", unit_ack);
    end
    step();
    drive(1'b0, '0, '0, 1'b0);
    tests++;
    if (count !== CW'(1) || wb_done !== 1'b1 || wb_id !== 3'd1 || wb_rd !== 32'hdead_0001) begin
      fails++;
      $display("FAIL reset_first_push: count=%0d done=%b id=%0d rd=%h want 1 1 1 dead0001",
               count, wb_done, wb_id, wb_rd);
    end
    drain();
  endtask

  task automatic test_single();
    drive(1'b1, 3'd2, 32'h0000_1234, 1'b1);
    tests++;
    if (unit_ack !== 1'b1 || wb_done !== BYP) begin
      fails++;
      $display("FAIL single_push: ack=%b done=%b want 1 %b", unit_ack, wb_done, BYP);
    end
    step();
    drive(1'b0, '0, '0, 1'b1);
    if (!BYP) begin
      tests++;
      if (wb_done !== 1'b1 || wb_id !== 3'd2 || wb_rd !== 32'h0000_1234 || count !== CW'(1)) begin
        fails++;
        $display("FAIL single_out: done=%b id=%0d rd=%h count=%0d want 1 2 00001234 1",
                 wb_done, wb_id, wb_rd, count);
      end
    end
    step();
    drive(1'b0, '0, '0, 1'b0);
    tests++;
    if (count !== '0 || wb_done !== 1'b0) begin
      fails++;
      $display("FAIL single_empty: count=%0d done=%b want 0 0", count, wb_done);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, IW'(i), $urandom, 1'b0);
      tests++;
      if (unit_ack !== (i < DEPTH)) begin
        fails++;
        $display("FAIL fill_ack_%0d: got %b want %b", i, unit_ack, (i < DEPTH));
      end
      if (i < 4) step();
    end
    tests++;
    if (count !== CW'(DEPTH) || wb_id !== 3'd0) begin
      fails++;
      $display("FAIL fill_count: count=%0d head=%0d want 4 0", count, wb_id);
    end
    drive(1'b1, 3'd4, 32'h0000_0444, 1'b1);
    tests++;
    if (unit_ack !== 1'b0) begin
      fails++;
      $display("FAIL full_ack_with_pop: got %b want 0", unit_ack);
    end
    step();
    drive(1'b1, 3'd4, 32'h0000_0444, 1'b0);
    tests++;
    if (unit_ack !== 1'b1 || count !== CW'(3) || wb_id !== 3'd1) begin
      fails++;
      $display("FAIL after_pop: ack=%b count=%0d head=%0d want 1 3 1", unit_ack, count, wb_id);
    end
    step();
    drive(1'b0, '0, '0, 1'b0);
    tests++;
    if (count !== CW'(DEPTH)) begin
      fails++;
      $display("FAIL refill_count: got %0d want 4", count);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      tests++;
      if (wb_done !== 1'b1 || wb_id !== IW'(i)) begin
        fails++;
        $display("FAIL fill_order_%0d: done=%b id=%0d want 1 %0d", i, wb_done, wb_id, i);
      end
      step();
    end
    drain();
  endtask

  task automatic test_wrap();
    logic [DW-1:0] seen[$];
    int sent = 0;
    for (int cyc = 0; cyc < 100 && (sent < 10 || q.size() != 0); cyc++) begin
      drive(sent < 10, IW'(sent), 32'h100 + DW'(sent), cyc[0]);
      tests++;
      if (unit_ack !== m_ack() || wb_done !== m_done() || count !== CW'(q.size()) || count > CW'(DEPTH)) begin
        fails++;
        $display("FAIL wrap_ctl_%0d: ack=%b done=%b count=%0d want %b %b %0d",
                 cyc, unit_ack, wb_done, count, m_ack(), m_done(), q.size());
      end
      if (wb_done && wb_ack) seen.push_back(wb_rd);
      if (unit_ack) sent++;
      step();
    end
    tests++;
    if (seen.size() != 10) begin
      fails++;
      $display("FAIL wrap_total: got %0d results want 10", seen.size());
    end
    for (int i = 0; i < seen.size() && i < 10; i++) begin
      tests++;
      if (seen[i] !== 32'h100 + DW'(i)) begin
        fails++;
        $display("FAIL wrap_order_%0d: got %h want %h", i, seen[i], 32'h100 + i);
      end
    end
    drain();
  endtask

  task automatic test_random();
    ent_t h;
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive($urandom_range(0, 2) != 0, IW'($urandom), $urandom, $urandom_range(0, 2) == 0);
      h = m_head();
      tests++;
      if (unit_ack !== m_ack() || wb_done !== m_done() || count !== CW'(q.size())) begin
        fails++;
        $display("FAIL rand_ctl_%0d: ack=%b done=%b count=%0d want %b %b %0d",
                 cyc, unit_ack, wb_done, count, m_ack(), m_done(), q.size());
      end
      if (m_done()) begin
        tests++;
        if (wb_id !== h.id || wb_rd !== h.rd) begin
          fails++;
          $display("FAIL rand_head_%0d: id=%0d rd=%h want %0d %h", cyc, wb_id, wb_rd, h.id, h.rd);
        end
      end
      step();
    end
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, IW'(i + 3), 32'hcafe_0000 + DW'(i), 1'b0);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    tests++;
    if (count !== CW'(3) || wb_done !== 1'b1) begin
      fails++;
      $display("FAIL areset_pre: count=%0d done=%b want 3 1", count, wb_done);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (wb_done !== 1'b0 || count !== '0) begin
      fails++;
      $display("FAIL areset_drop: done=%b count=%0d want 0 0", wb_done, count);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3'd5, 32'h5a5a_0005, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1);
    tests++;
    if (wb_done !== 1'b1 || wb_id !== 3'd5 || wb_rd !== 32'h5a5a_0005 || count !== CW'(1)) begin
      fails++;
      $display("FAIL areset_after: done=%b id=%0d rd=%h count=%0d want 1 5 5a5a0005 1",
               wb_done, wb_id, wb_rd, count);
    end
    step();
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_result_buffer.md
Name: wb_result_buffer

Overview:
- Decoupling FIFO between an execution unit's writeback port (e.g. the multiplier's rd/done/id/ack) and the writeback arbiter.
- Absorbs results while the arbiter services other units, so the multiplier pipeline keeps advancing instead of stalling on ack.
- Preserves result order, one entry per accepted result.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- DATA_WIDTH, 32, width of the rd result.
- ID_WIDTH, 3, width of the instruction id tag (matches id_t).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- unit_done  in  1  upstream unit has a valid result.
- unit_id  in  ID_WIDTH  id of the upstream result.
- unit_rd  in  DATA_WIDTH  upstream result data.
- unit_ack  out  1  result accepted this cycle.
- wb_done  out  1  buffer presents a valid result to the arbiter.
- wb_id  out  ID_WIDTH  id of the presented result.
- wb_rd  out  DATA_WIDTH  presented result data.
- wb_ack  in  1  arbiter consumes the presented result this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release): read/write pointers = 0, count = 0, wb_done = 0, unit_ack = 0. wb_id/wb_rd are don't-care while wb_done = 0. Storage contents are not reset.
- push = unit_done & ~full; unit_ack = push (combinational from unit_done and registered full).
- No full-bypass: when full, unit_ack = 0 even if wb_ack = 1 in the same cycle. This keeps ack independent of wb_ack.
- pop = wb_done & wb_ack. wb_ack while wb_done = 0 is ignored.
- wb_done = ~empty; wb_id/wb_rd = head entry (registered storage, no combinational path from unit_* to wb_*).
- Latency: a result pushed in cycle N is visible on wb_* in cycle N+1 at the earliest.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. full/empty come from count (count == DEPTH / count == 0).
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Simultaneous push and pop when count == 1: head advances to the new entry; wb_done stays 1.
- Simultaneous push and pop when empty is impossible (pop requires wb_done).
- Order is strictly FIFO; results are never dropped or duplicated.
- unit_id/unit_rd are sampled only when push = 1.
- rst_n asserted mid-operation: all entries are discarded immediately and wb_done drops asynchronously. Upstream is reset by the same reset.

Optional Feature:
- Macro WB_BUFFER_BYPASS_EN.
- Defined:
  - When empty, wb_done = unit_done and wb_id/wb_rd = unit_id/unit_rd, combinationally (zero latency).
  - If wb_ack is also high, the result is acked upstream and not written; count stays 0.
  - If wb_ack is low, it is pushed as normal.
- Not defined: bypass logic is absent; the minimum latency is 1 cycle as above.

Test Plan:
- Reset: hold rst_n = 0 with unit_done = 1 -> wb_done = 0, unit_ack = 0, count = 0. Release -> first result accepted the next cycle.
- Single pass: push id=2, rd=0x0000_1234 with wb_ack held 1 -> wb_done = 1 with id 2 / 0x1234 one cycle later, popped that cycle, count back to 0. With WB_BUFFER_BYPASS_EN: same-cycle output, count stays 0.
- Fill, DEPTH = 4, wb_ack = 0: push ids 0..4 back-to-back -> acks for ids 0..3, unit_ack = 0 for id 4, count = 4. Pulsing wb_ack with unit_done held -> id 4 accepted one cycle after the pop.
- Full plus simultaneous wb_ack: count = 4, wb_ack = 1, unit_done = 1 -> unit_ack = 0 that cycle, count = 3. Next cycle unit_ack = 1.
- Wrap-around: stream 10 results (rd = 0x100+i) with wb_ack toggling every other cycle -> outputs in exact order 0x100..0x109, none lost, count never exceeds 4.
- Async reset mid-stream: count = 3, drop rst_n between clock edges -> wb_done falls immediately, count = 0. After release, the next push appears with no stale data.
